// File: rtl/alu_issuer.sv
`default_nettype none
// ============================================================================
// alu_issuer : valid/ready front end that issues one instruction to the 4-bit
//              operator, waits LAT edges, then returns the sampled result.
// Revision   : 1.0
// ============================================================================
module alu_issuer #(
    parameter int LAT = 3,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [7:0]   req_instr,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [7:0]   op_instr,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    input  logic [W-1:0] op_result,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [2:0]   res_op,
    output logic         res_err,
    output logic         busy,
    output logic [7:0]   op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_lat       = 4'(LAT);
    localparam logic [2:0] c_op_unsup  = 3'd6;

    state_t         r_state;
    state_t         w_next_state;
    logic [3:0]     r_cnt;
    logic [7:0]     r_op_instr;
    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;
    logic           r_res_valid;
    logic [W-1:0]   r_res_data;
    logic [2:0]     r_res_op;
    logic           r_res_err;
    logic [7:0]     r_op_count;

    logic [2:0]     w_req_op;
    logic [2:0]     w_cur_op;
    logic           w_accept;
    logic           w_unsup;
    logic           w_two_operand;
    logic           w_sample;
    logic           w_res_hs;
    logic           w_flag_op;
    logic [W-1:0]   w_sampled;

    assign w_req_op      = req_instr[7:5];
    assign w_cur_op      = r_op_instr[7:5];
    assign w_accept      = req_valid && (r_state == S_IDLE);
    assign w_unsup       = (w_req_op == c_op_unsup);
    assign w_two_operand = (w_req_op == 3'd0) || (w_req_op == 3'd4) || (w_req_op == 3'd5);
    assign w_sample      = (r_state == S_WAIT) && (r_cnt == 4'd1);
    assign w_res_hs      = (r_state == S_DONE) && res_ready;

    // Compare opcodes drive all result bits alike; only bit 0 carries the flag.
    assign w_flag_op = (w_cur_op == 3'd4) || (w_cur_op == 3'd5);
    assign w_sampled = w_flag_op ? {{(W-1){1'b0}}, op_result[0]} : op_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = w_unsup ? S_DONE : S_WAIT;
            S_WAIT:  if (w_sample) w_next_state = S_DONE;
            S_DONE:  if (w_res_hs) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_op_instr  <= 8'd0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_op    <= 3'd0;
            r_res_err   <= 1'b0;
            r_op_count  <= 8'd0;
        end else begin
            if (w_accept && !w_unsup) begin
                r_op_instr <= req_instr;
                r_op_a     <= req_a;
                r_op_b     <= w_two_operand ? req_b : '0;
                r_cnt      <= c_lat;
            end
            // Unsupported opcodes never touch the operator; answer immediately.
            if (w_accept && w_unsup) begin
                r_res_data  <= '0;
                r_res_op    <= c_op_unsup;
                r_res_err   <= 1'b1;
                r_res_valid <= 1'b1;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_sample) begin
                r_res_data  <= w_sampled;
                r_res_op    <= w_cur_op;
                r_res_err   <= 1'b0;
                r_res_valid <= 1'b1;
            end
            if (w_res_hs) begin
                r_res_valid <= 1'b0;
                if (!r_res_err) begin
                    r_op_count <= r_op_count + 8'd1;
                end
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign op_instr  = r_op_instr;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_op    = r_res_op;
    assign res_err   = r_res_err;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issuer.sv
`default_nettype none
// ============================================================================
// tb_alu_issuer : randomized self-checking bench with an operator model and a
//                 behavioural reference for the issuer's responses.
// Revision      : 1.0
// ============================================================================
module tb_alu_issuer;

    localparam int LAT = 3;
    localparam int W   = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_instr;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic [7:0]   op_instr;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] op_result;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [2:0]   res_op;
    logic         res_err;
    logic         busy;
    logic [7:0]   op_count;

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           last_acc = 0;
    logic [7:0]   exp_count = 8'd0;

    alu_issuer #(.LAT(LAT), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_instr (req_instr),
        .req_a     (req_a),
        .req_b     (req_b),
        .op_instr  (op_instr),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_result (op_result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_err   (res_err),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Operator model: compare opcodes assert every result bit.
    always_comb begin
        case (op_instr[7:5])
            3'd0:    op_result = op_a + op_b;
            3'd1:    op_result = ~op_a;
            3'd2:    op_result = op_a << 1;
            3'd3:    op_result = op_a >> 1;
            3'd4:    op_result = (op_a == op_b) ? 4'hF : 4'h0;
            3'd5:    op_result = (op_a < op_b) ? 4'hF : 4'h0;
            3'd7:    op_result = op_a + 4'd1;
            default: op_result = 4'hA;
        endcase
    end

    function automatic logic [3:0] ref_result(input logic [2:0] op, input logic [3:0] a,
                                              input logic [3:0] b);
        int s;
        case (op)
            3'd0: begin s = (int'(a) + int'(b)) % 16; return 4'(s); end
            3'd1: return 4'hF ^ a;
            3'd2: return {a[2:0], 1'b0};
            3'd3: return {1'b0, a[3:1]};
            3'd4: return (a == b) ? 4'd1 : 4'd0;
            3'd5: return (int'(a) < int'(b)) ? 4'd1 : 4'd0;
            3'd7: begin s = (int'(a) + 1) % 16; return 4'(s); end
            default: return 4'd0;
        endcase
    endfunction

    // hold < 0: res_ready high throughout; else res_ready low for hold cycles.
    task automatic do_op(input logic [7:0] instr, input logic [3:0] a, input logic [3:0] b,
                         input int hold, input bit poke);
        logic [2:0] op;
        logic [3:0] exp_data, exp_b;
        logic [7:0] exp_instr;
        logic [3:0] exp_a;
        logic       exp_err;
        int         k;
        op        = instr[7:5];
        exp_err   = (op == 3'd6);
        exp_data  = ref_result(op, a, b);
        exp_b     = (op == 3'd0 || op == 3'd4 || op == 3'd5) ? b : 4'd0;
        exp_instr = exp_err ? op_instr : instr;
        exp_a     = exp_err ? op_a : a;
        if (exp_err) exp_b = op_b;
        res_ready = (hold < 0);
        req_valid = 1'b1; req_instr = instr; req_a = a; req_b = b;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++; $display("FAIL req_ready_idle: got %b expected 1", req_ready);
        end
        @(negedge clk);
        last_acc  = cyc;
        req_valid = 1'b0; req_instr = 8'($urandom); req_a = 4'($urandom); req_b = 4'($urandom);
        checks++;
        if (op_instr !== exp_instr || op_a !== exp_a || op_b !== exp_b) begin
            failures++;
            $display("FAIL op_drive: got %h/%h/%h expected %h/%h/%h",
                     op_instr, op_a, op_b, exp_instr, exp_a, exp_b);
        end
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
            failures++; $display("FAIL busy_after_accept: got busy=%b ready=%b expected 1/0", busy, req_ready);
        end
        k = 0;
        while (res_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != (exp_err ? 0 : LAT)) begin
            failures++; $display("FAIL latency: got %0d expected %0d", k, exp_err ? 0 : LAT);
        end
        if (res_valid !== 1'b1) begin
            res_ready = 1'b0;
            return;
        end
        checks++;
        if (res_data !== exp_data || res_op !== op || res_err !== exp_err) begin
            failures++;
            $display("FAIL response: got data=%h op=%0d err=%b expected data=%h op=%0d err=%b",
                     res_data, res_op, res_err, exp_data, op, exp_err);
        end
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid = 1'b1; req_instr = 8'h20; req_a = 4'($urandom); req_b = 4'($urandom);
            end
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== exp_data || res_op !== op ||
                res_err !== exp_err || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold: got v=%b d=%h op=%0d e=%b rdy=%b expected 1/%h/%0d/%b/0",
                         res_valid, res_data, res_op, res_err, req_ready, exp_data, op, exp_err);
            end
        end
        req_valid = 1'b0;
        if (poke) begin
            checks++;
            if (op_instr !== exp_instr || op_a !== exp_a) begin
                failures++; $display("FAIL ignored_request: got %h/%h expected %h/%h",
                                     op_instr, op_a, exp_instr, exp_a);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        if (!exp_err) exp_count = exp_count + 8'd1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL handshake: got v=%b busy=%b rdy=%b expected 0/0/1",
                                 res_valid, busy, req_ready);
        end
        checks++;
        if (op_count !== exp_count) begin
            failures++; $display("FAIL op_count: got %0d expected %0d", op_count, exp_count);
        end
        checks++;
        if (res_data !== exp_data || res_op !== op || res_err !== exp_err) begin
            failures++; $display("FAIL response_kept: got %h/%0d/%b expected %h/%0d/%b",
                                 res_data, res_op, res_err, exp_data, op, exp_err);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (op_instr !== 8'd0 || op_a !== 4'd0 || op_b !== 4'd0 || res_valid !== 1'b0 ||
            res_data !== 4'd0 || res_op !== 3'd0 || res_err !== 1'b0 || busy !== 1'b0 ||
            op_count !== 8'd0) begin
            failures++;
            $display("FAIL %s: got %h %h %h %b %h %0d %b %b %0d expected all zero", name,
                     op_instr, op_a, op_b, res_valid, res_data, res_op, res_err, busy, op_count);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_instr = 8'h00; req_a = 4'd1; req_b = 4'd2;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_release: got rdy=%b busy=%b expected 1/0", req_ready, busy);
        end
    endtask

    task automatic test_add();
        do_op(8'h00, 4'd9, 4'd9, 0, 1'b0);
    endtask

    task automatic test_shift();
        do_op(8'h40, 4'b0111, 4'hF, 1, 1'b0);
    endtask

    task automatic test_compare();
        do_op(8'h80, 4'd5, 4'd5, 0, 1'b0);
        do_op(8'h80, 4'd5, 4'd6, 0, 1'b0);
        do_op(8'hA0, 4'd2, 4'd9, 0, 1'b0);
    endtask

    task automatic test_unsupported();
        do_op(8'hC0, 4'd3, 4'd4, 2, 1'b1);
    endtask

    task automatic test_backpressure();
        do_op(8'h00, 4'd6, 4'd5, 5, 1'b1);
        do_op(8'h60, 4'hB, 4'd1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int prev;
        do_op(8'h00, 4'd1, 4'd2, -1, 1'b0);
        prev = last_acc;
        for (int i = 0; i < 4; i++) begin
            do_op({3'(i), 5'd0}, 4'($urandom), 4'($urandom), -1, 1'b0);
            checks++;
            if (last_acc - prev != LAT + 2) begin
                failures++; $display("FAIL throughput: got %0d expected %0d", last_acc - prev, LAT + 2);
            end
            prev = last_acc;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            do_op(8'($urandom), 4'($urandom), 4'($urandom),
                  int'($urandom_range(0, 4)) - 1, 1'($urandom));
        end
    endtask

    task automatic test_wrap();
        while (exp_count != 8'hFF) begin
            do_op({3'd0, 5'($urandom)}, 4'($urandom), 4'($urandom), -1, 1'b0);
        end
        do_op(8'h20, 4'd3, 4'd0, -1, 1'b0);
        do_op(8'h00, 4'd1, 4'd1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 1'b1; req_instr = 8'h00; req_a = 4'd9; req_b = 4'd1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_wait");
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 8'd0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL aborted_op: got v=%b busy=%b expected 0/0", res_valid, busy);
            end
        end
        do_op(8'h00, 4'd3, 4'd4, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_compare();
        test_unsupported();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_wrap();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
